// File: rtl/seg_display_pkg.sv
// Purpose : shared types and constants for the 7-segment scan controller slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, BCD nibble type, DIGIT_OFF anode level, prescaler width helper.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_nibble_t;

  // Common-anode display: a high anode line turns the digit off.
  localparam logic DIGIT_OFF = 1'b1;

  // Width of a counter running 0..scan_div-1; never less than one bit.
  function automatic int prescaler_width(input int scan_div);
    return (scan_div > 1) ? $clog2(scan_div) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Purpose : sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency : BIN_WIDTH cycles after the start edge; done is high during the last step.
// Backpressure: none; start is only honoured by the caller when idle, result holds until next start.
// Ports   : clk, rst (async active-high), start, bin_in -> done (last-step flag), bcd_out (NUM_DIGITS nibbles).
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  // BCD digits sit above the binary operand; each step shifts one binary bit in.
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // Add-3 correction on every BCD nibble that would exceed 9 after doubling.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (sr[BIN_WIDTH + 4*d +: 4] >= 4'd5) begin
        sr_adj[BIN_WIDTH + 4*d +: 4] = sr[BIN_WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign done    = busy && (cnt == CNT_W'(BIN_WIDTH - 1));
  assign bcd_out = sr[SR_W-1 -: BCD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sr   <= {{BCD_W{1'b0}}, bin_in};
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      sr <= sr_adj << 1;
      if (done) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Purpose : accept a binary value, convert to BCD, time-multiplex it onto a common-anode display.
// Latency : new digits reach selected_digit_data BIN_WIDTH+1 cycles after the accepting edge.
// Backpressure: value_ready low from accept until COMMIT; unaccepted values must be held by the source.
// Ports   : clk, rst (async active-high), value_in/value_valid/value_ready handshake,
//           selected_digit_data (BCD nibble), anode (one-hot active-low), overflow (saturation flag).
// Option  : define LEADING_ZERO_BLANK_EN to turn off leading-zero digits (units digit always lit).
module seven_seg_scan_controller
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int SCAN_DIV   = 12500,
  parameter int MAX_VALUE  = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [3:0]            selected_digit_data,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PRE_W = prescaler_width(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [BIN_WIDTH-1:0] MAX_V = BIN_WIDTH'(MAX_VALUE);

  state_t                state;
  logic                  accept;
  logic                  over_max;
  logic [BIN_WIDTH-1:0]  sat_value;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic [BCD_W-1:0]      disp;
  logic [BCD_W-1:0]      scan_src;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  scan_tc;
  logic                  digit_on;
  bcd_nibble_t           nib_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  seen_nz;
`endif

  assign over_max  = (value_in > MAX_V);
  assign sat_value = over_max ? MAX_V : value_in;
  assign accept    = (state == IDLE) && value_valid && value_ready;

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .bin_in  (sat_value),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // Handshake / conversion sequencer. The display register only moves in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      value_ready <= 1'b0;
      overflow    <= 1'b0;
      disp        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            overflow    <= over_max;
            value_ready <= 1'b0;
            state       <= CONVERT;
          end else begin
            value_ready <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp        <= conv_bcd;
          value_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          value_ready <= 1'b0;
        end
      endcase
    end
  end

  // Next scan slot and its outputs. During COMMIT the fresh result is forwarded so the
  // new digit lands on the same edge the display register loads, including a slot change.
  always_comb begin
    scan_tc = (pre == PRE_W'(SCAN_DIV - 1));
    idx_nxt = idx;
    if (scan_tc) begin
      idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    scan_src = (state == COMMIT) ? conv_bcd : disp;

    nib_nxt = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_nxt == IDX_W'(d)) begin
        nib_nxt = scan_src[4*d +: 4];
      end
    end

    digit_on = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit is lit once a nonzero digit (or the units) is reached.
    seen_nz = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      seen_nz = seen_nz | (scan_src[4*d +: 4] != 4'd0) | (d == 0);
      if (idx_nxt == IDX_W'(d)) begin
        digit_on = seen_nz;
      end
    end
`endif

    anode_nxt = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      anode_nxt[d] = (digit_on && (idx_nxt == IDX_W'(d))) ? ~DIGIT_OFF : DIGIT_OFF;
    end
  end

  // Free-running scanner; anode and digit share one register stage to avoid skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre                 <= '0;
      idx                 <= '0;
      anode               <= '1;
      selected_digit_data <= '0;
    end else begin
      pre                 <= scan_tc ? '0 : pre + 1'b1;
      idx                 <= idx_nxt;
      anode               <= anode_nxt;
      selected_digit_data <= nib_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Purpose : self-checking bench for seven_seg_scan_controller (SCAN_DIV shortened to 4).
// Latency : n/a.
// Backpressure: source holds value_valid until value_ready is seen.
module tb_seven_seg_scan_controller;

  localparam int ND   = 4;
  localparam int BW   = 14;
  localparam int SD   = 4;
  localparam int MAXV = 9999;
  localparam int LAT  = BW + 2;  // accept edge to COMMIT edge is BW+1; +1 for the pre-edge negedge

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] value_in = '0;
  logic          value_valid = 1'b0;
  logic          value_ready;
  logic [3:0]    selected_digit_data;
  logic [ND-1:0] anode;
  logic          overflow;

  always #5 clk = ~clk;

  seven_seg_scan_controller #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .SCAN_DIV   (SD),
    .MAX_VALUE  (MAXV)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .value_in            (value_in),
    .value_valid         (value_valid),
    .value_ready         (value_ready),
    .selected_digit_data (selected_digit_data),
    .anode               (anode),
    .overflow            (overflow)
  );

  typedef struct {
    logic [BW-1:0] value;
    logic [15:0]   bcd;
    logic          ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[10];
  int          checks = 0;
  int          passed = 0;
  int          cyc;
  logic [15:0] shown = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > MAXV) ? MAXV : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Edges since reset release; the scan slot follows from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Output monitor: pops the scoreboard when a result is due and checks every scan slot.
  always @(negedge clk) begin : mon
    int         idx;
    logic [3:0] ea;
    logic [3:0] es;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("commit_ready", 32'(value_ready), 32'd1);
        check("commit_overflow", 32'(overflow), 32'(sb[0].ovf));
        shown = sb[0].bcd;
        void'(sb.pop_front());
      end
      if (cyc == 0) begin
        ea = '1;
        es = '0;
        check("ready_before_first_edge", 32'(value_ready), 32'd0);
      end else begin
        idx    = (cyc / SD) % ND;
        es     = shown[4*idx +: 4];
        ea     = '1;
        ea[idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (shown >> (4*idx)) == 16'd0) ea = '1;
`endif
      end
      if (cyc == 1) check("ready_first_edge", 32'(value_ready), 32'd1);
      check("anode", 32'(anode), 32'(ea));
      check("digit", 32'(selected_digit_data), 32'(es));
    end
  end

  task automatic send(input logic [BW-1:0] v, input logic [15:0] bcd, input logic ovf);
    int n;
    n = 0;
    @(negedge clk);
    while (!value_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!value_ready) begin
      check("ready_timeout", 32'(value_ready), 32'd1);
      return;
    end
    value_in    = v;
    value_valid = 1'b1;
    sb.push_back('{bcd, ovf, cyc + LAT});
    @(negedge clk);
    value_valid = 1'b0;
    value_in    = $urandom_range(0, 16383);  // junk while not valid
    check("ready_drop", 32'(value_ready), 32'd0);
    check("overflow_at_accept", 32'(overflow), 32'(ovf));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (ND * SD) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int last;
    logic [BW-1:0] v;

    tbl[0] = '{14'd1234,  16'h1234, 1'b0};
    tbl[1] = '{14'd12000, 16'h9999, 1'b1};
    tbl[2] = '{14'd5,     16'h0005, 1'b0};
    tbl[3] = '{14'd0,     16'h0000, 1'b0};
    tbl[4] = '{14'd9999,  16'h9999, 1'b0};
    tbl[5] = '{14'd10000, 16'h9999, 1'b1};
    tbl[6] = '{14'd16383, 16'h9999, 1'b1};
    tbl[7] = '{14'd908,   16'h0908, 1'b0};
    tbl[8] = '{14'd70,    16'h0070, 1'b0};
    tbl[9] = '{14'd4321,  16'h4321, 1'b0};

    // Reset state while rst is high.
    #12;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_digit", 32'(selected_digit_data), 32'd0);
    check("rst_ready", 32'(value_ready), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Release and let "0000" scan through a couple of full rotations.
    release_reset();
    repeat (2 * ND * SD + 2) @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].value, tbl[i].bcd, tbl[i].ovf);
      drain();
    end

    // valid held high with changing data: accepts every BW+2 cycles.
    last = -1;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      v           = BW'($urandom_range(0, 16383));
      value_in    = v;
      value_valid = 1'b1;
      if (value_ready) begin
        sb.push_back('{to_bcd(int'(v)), (int'(v) > MAXV), cyc + LAT});
        if (last >= 0) check("accept_spacing", 32'(cyc + 1 - last), 32'(BW + 2));
        last = cyc + 1;
      end
      @(negedge clk);
    end
    value_valid = 1'b0;
    drain();

    // COMMIT on the same edge as a scan step.
    while ((cyc % SD) != SD - 1) @(negedge clk);
    send(14'd8765, 16'h8765, 1'b0);
    drain();
    // And COMMIT one edge before a scan step.
    while ((cyc % SD) != SD - 2) @(negedge clk);
    send(14'd3146, 16'h3146, 1'b0);
    drain();

    // Reset during CONVERT of a saturating value.
    send(14'd12000, 16'h9999, 1'b1);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_anode", 32'(anode), 32'hF);
    check("midrst_digit", 32'(selected_digit_data), 32'd0);
    check("midrst_ready", 32'(value_ready), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    sb.delete();
    shown = '0;
    repeat (3) @(posedge clk);
    release_reset();
    repeat (2 * ND * SD + 2) @(negedge clk);

    // Display recovers normally after the abandoned conversion.
    send(14'd42, 16'h0042, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
